// File: rtl/a2d_pkg.sv
// Shared FSM state type and SPI frame constants for the ADC128S interface.
// No logic here; imported by a2d_intf and spi_mstr16.
package a2d_pkg;
  typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} state_t;

  localparam int FRONT_PORCH = 9;
  localparam int FRAME_BITS  = 16;
endpackage

// File: rtl/spi_mstr16.sv
// One 16-bit SPI frame, SCLK idles high, MISO sampled on SCLK rise; 9 + 16*SCLK_DIV clks per frame.
// done is a one-clk strobe on the final shift with rd_data valid alongside; wrt ignored mid-frame.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV - FRONT_PORCH);
  localparam logic [DW-1:0] DIV_RISE = DW'(SCLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_FALL = '1;

  logic [DW-1:0] r_div;
  logic [4:0]    r_bit_cnt;
  logic [15:0]   r_shft;
  logic          r_smpl;
  logic          r_ss_n;
  logic          r_sclk;
  logic [DW-1:0] w_div_nxt;
  logic          w_rise;
  logic          w_fall;
  logic          w_last;

  assign w_div_nxt = r_div + DW'(1);
  assign w_rise    = ~r_ss_n & (r_div == DIV_RISE);
  assign w_fall    = ~r_ss_n & (r_div == DIV_FALL);
  // Fall point 0 ends the porch and shifts nothing, so the 16th shift lands on count 16.
  assign w_last    = w_fall & (r_bit_cnt == 5'(FRAME_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shft    <= '0;
      r_smpl    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_sclk    <= 1'b1;
    end else if (r_ss_n) begin
      if (wrt) begin
        r_ss_n    <= 1'b0;
        r_div     <= DIV_LOAD;
        r_bit_cnt <= '0;
        r_shft    <= cmd;
        r_sclk    <= DIV_LOAD[DW-1];
      end
    end else begin
      r_div <= w_div_nxt;
      if (w_rise) r_smpl <= MISO;
      if (w_fall) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        if (r_bit_cnt != 5'd0) r_shft <= {r_shft[14:0], r_smpl};
      end
      // SCLK is registered from the next divider value so the pin never shows a 17th fall.
      if (w_last) begin
        r_ss_n <= 1'b1;
        r_sclk <= 1'b1;
      end else begin
        r_sclk <= w_div_nxt[DW-1];
      end
    end
  end

  assign done    = w_last;
  assign rd_data = {r_shft[14:0], r_smpl};
  assign SS_n    = r_ss_n;
  assign SCLK    = r_sclk;
  assign MOSI    = r_shft[15];
endmodule

// File: rtl/a2d_intf.sv
// ADC128S channel read: address frame, SS_n gap, result frame; cnv_cmplt 1075 clks after strt_cnv.
// No backpressure: strt_cnv outside IDLE is dropped. Define A2D_INV_EN to return 12'hFFF - raw.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);
  localparam int GW = $clog2(GAP_CLKS + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gap;
  logic [11:0]   r_res;
  logic          r_cmplt;
  logic [11:0]   w_res_nxt;
  logic          w_start;
  logic          w_gap_end;
  logic          w_wrt;
  logic          w_done;
  logic [15:0]   w_cmd;
  logic [15:0]   w_rd;
  logic          w_rd_unused;

  assign w_start   = (r_state == IDLE) & strt_cnv;
  assign w_gap_end = (r_state == GAP) & (r_gap == GW'(GAP_CLKS - 1));
  assign w_wrt     = w_start | w_gap_end;
  // The frame engine's shift register is the channel latch: it loads on the accepting clk.
  assign w_cmd     = w_start ? {2'b00, chnnl, 11'h000} : 16'h0000;

`ifdef A2D_INV_EN
  assign w_res_nxt = 12'hFFF - w_rd[11:0];
`else
  assign w_res_nxt = w_rd[11:0];
`endif
  assign w_rd_unused = ^w_rd[15:12];

  spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (w_wrt),
    .cmd     (w_cmd),
    .done    (w_done),
    .rd_data (w_rd),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (strt_cnv)  w_state_nxt = FRM1;
      FRM1:    if (w_done)    w_state_nxt = GAP;
      GAP:     if (w_gap_end) w_state_nxt = FRM2;
      FRM2:    if (w_done)    w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap   <= '0;
      r_res   <= 12'h000;
      r_cmplt <= 1'b0;
    end else begin
      r_gap <= (r_state == GAP) ? r_gap + GW'(1) : '0;
      if (w_start) r_cmplt <= 1'b0;
      if ((r_state == FRM2) && w_done) begin
        r_res   <= w_res_nxt;
        r_cmplt <= 1'b1;
      end
    end
  end

  assign res       = r_res;
  assign cnv_cmplt = r_cmplt;
endmodule
